// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt controller and its per-channel slices.
package irq_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Width of a channel index; never zero so a single-channel build still has an id port.
  function automatic int id_width(input int n_ch);
    return (n_ch <= 2) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/irq_channel.sv
// One interrupt channel: input synchronizer, polarity conditioning, edge/level
// event detection and the sticky pending bit.
module irq_channel #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  input  logic invert,
  input  logic edge_mode,
  input  logic armed,
  input  logic clr,
  output logic sync_out,
  output logic pending
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   cond;
  logic                   prev;
  logic                   evt;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign cond     = sync_out ^ invert;
  assign evt      = armed & (edge_mode ? (cond & ~prev) : cond);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the sync chain is reset too so sync_out reads 0 in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
      prev   <= cond;
      // A new event beats a simultaneous acceptance so the interrupt is not lost.
      if (evt) begin
        pending <= 1'b1;
      end else if (clr) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: N_CH synchronized channels, a post-reset arm window,
// fixed lowest-index-first priority and a present/acknowledge handshake.
module irq_controller
  import irq_pkg::*;
#(
  parameter  int N_CH        = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int ID_W        = id_width(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] irq_in,
  input  logic [N_CH-1:0] invert,
  input  logic [N_CH-1:0] edge_mode,
  input  logic [N_CH-1:0] mask,
  output logic [N_CH-1:0] sync_out,
  output logic [N_CH-1:0] pending,
  output logic            irq_valid,
  output logic [ID_W-1:0] irq_id,
  input  logic            irq_ack
);

  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int CNT_W      = $clog2(ARM_CYCLES + 1);

  logic [CNT_W-1:0] arm_cnt;
  logic             armed;
  logic [N_CH-1:0]  clr;
  logic [N_CH-1:0]  ready;
  logic             hit;
  logic [ID_W-1:0]  low_id;
  logic             accept;
  state_t           state;
  state_t           state_next;
  logic [ID_W-1:0]  id_next;

  // Events stay blocked until the sync chains and prev flops hold real input history.
  assign armed = (arm_cnt == CNT_W'(ARM_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) begin
      arm_cnt <= '0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    irq_channel #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .irq_in   (irq_in[g]),
      .invert   (invert[g]),
      .edge_mode(edge_mode[g]),
      .armed    (armed),
      .clr      (clr[g]),
      .sync_out (sync_out[g]),
      .pending  (pending[g])
    );
  end

  assign ready     = pending & mask;
  assign irq_valid = (state == PRESENT);
  assign accept    = irq_valid & irq_ack;

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    hit    = 1'b0;
    low_id = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        hit    = 1'b1;
        low_id = ID_W'(i);
      end
    end
  end

  always_comb begin
    clr = '0;
    for (int i = 0; i < N_CH; i++) begin
      clr[i] = accept && (irq_id == ID_W'(i));
    end
  end

  always_comb begin
    state_next = state;
    id_next    = irq_id;
    case (state)
      IDLE: begin
        if (hit) begin
          state_next = PRESENT;
          id_next    = low_id;
        end
      end
      PRESENT: begin
        if (irq_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      irq_id <= '0;
    end else begin
      state  <= state_next;
      irq_id <= id_next;
    end
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 The block SHALL have parameter N_CH, default 8, giving the number of interrupt channels (1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth (2..4).
REQ-003 The block SHALL have derived constant ID_W = max(1, clog2(N_CH)).
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port irq_in, input, N_CH bits: raw asynchronous interrupt sources.
REQ-007 The block SHALL have port invert, input, N_CH bits: 1 means the channel is active-low.
REQ-008 The block SHALL have port edge_mode, input, N_CH bits: 1 means rising-edge latched, 0 means level.
REQ-009 The block SHALL have port mask, input, N_CH bits: 1 means the channel may be presented.
REQ-010 The block SHALL have port sync_out, output, N_CH bits: synchronized, un-inverted levels.
REQ-011 The block SHALL have port pending, output, N_CH bits: pending latch state.
REQ-012 The block SHALL have port irq_valid, output, 1 bit: an interrupt is being presented.
REQ-013 The block SHALL have port irq_id, output, ID_W bits: index of the presented channel.
REQ-014 The block SHALL have port irq_ack, input, 1 bit: consumer accepts the presented interrupt.

Function
REQ-015 Each irq_in bit SHALL pass through a SYNC_STAGES flop chain; sync_out is the last stage.
REQ-016 Conditioned level cond[i] SHALL equal sync_out[i] XOR invert[i]; prev[i] SHALL register cond[i] every cycle.
REQ-017 Event: edge_mode[i]=1 means cond[i] & ~prev[i]; edge_mode[i]=0 means cond[i].
REQ-018 All events SHALL be suppressed while an arm counter is below SYNC_STAGES+1 cycles after reset deassertion; this prevents false events from reset values.
REQ-019 An event SHALL set pending[i] at the next edge, independent of mask.
REQ-020 Acceptance SHALL clear pending[irq_id] at the next edge; if a set and a clear hit the same bit in one cycle, the set wins.
REQ-021 The FSM SHALL have states IDLE and PRESENT; irq_valid = (state == PRESENT).
REQ-022 IDLE to PRESENT: when (pending & mask) != 0, latch irq_id = the lowest set index.
REQ-023 PRESENT to IDLE: on irq_ack=1; the earliest next presentation is the cycle after IDLE (one bubble cycle).
REQ-024 In PRESENT, irq_id SHALL stay frozen; higher-priority arrivals or mask changes never retract or alter it.
REQ-025 irq_ack while in IDLE SHALL be ignored, with no pending bit changed.
REQ-026 Latency: a raw edge stable before edge 1 SHALL give pending at edge SYNC_STAGES+1 and irq_valid at edge SYNC_STAGES+2 (4 cycles by default) when IDLE, masked in, and highest priority.
REQ-027 A level-mode channel that is still active after acceptance SHALL re-pend on the following cycle.
REQ-028 Edge-mode edges on an already-pending channel SHALL merge into the single pending bit (no count).

Reset
REQ-029 While reset=1, at each edge, the sync chains, prev, pending, arm counter and irq_id SHALL all clear to 0 and the state SHALL go to IDLE.
REQ-030 Outputs during reset: irq_valid=0, irq_id=0, pending=0, sync_out=0.
REQ-031 A reset during PRESENT SHALL drop irq_valid at the next edge, with no acceptance.

Structure
REQ-032 The state encoding and the ID_W computation function SHALL live in shared package irq_pkg.
REQ-033 A per-channel sub-module irq_channel (sync chain, conditioning, edge detect, pending bit) SHALL be instantiated N_CH times; the top holds the arm counter, priority encoder and FSM.
REQ-034 The block SHALL be instantiable in the FPGC top-level to replace the fixed stabilizer and the hard-wired CPU interrupt lines.

Verification
REQ-035 Default params, ch3 edge, unmasked: raw 0->1 -> irq_valid high 4 cycles later, irq_id=3; ack -> pending[3]=0 and irq_valid=0 next cycle.
REQ-036 Ch1 and ch5 pending together, both masked in -> id 1 presented first; after ack plus one bubble -> id 5.
REQ-037 Ch2 level-mode, invert=1, irq_in idle high during and after reset -> no pending within 10 cycles; drive low -> irq_id=2; hold low and ack -> re-presented.
REQ-038 Ch0 masked off and pending -> irq_valid stays 0; set mask[0] -> presented 1 cycle later; clear mask while PRESENT -> irq_id=0 stays until ack.
REQ-039 Ack arrives on the same cycle as a new ch4 edge with ch4 presented -> pending[4] stays 1 and ch4 is re-presented.
REQ-040 Assert reset during PRESENT -> irq_valid=0 and pending=0 next edge; raw inputs held constant after release -> no event.
